// File: rtl/sample_packer_pkg.sv
// rtl/sample_packer_pkg.sv - shared encodings and helpers for the ADC sample packer
package sample_packer_pkg;

  localparam int WORDS_PER_PACKET = 512;

  localparam logic [1:0] MODE_1B = 2'd0;
  localparam logic [1:0] MODE_2B = 2'd1;
  localparam logic [1:0] MODE_4B = 2'd2;

  typedef enum logic [1:0] {
    SLOT_2B = 2'd0,
    SLOT_4B = 2'd1,
    SLOT_8B = 2'd2
  } slot_width_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Reserved mode 3 packs like 2b.
  function automatic logic [3:0] samples_per_word(input logic [1:0] mode);
    case (mode)
      MODE_1B: return 4'd8;
      MODE_4B: return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/sample_requant.sv
// rtl/sample_requant.sv - requantizes one complex sample to a left-justified {I,Q} field
module sample_requant
  import sample_packer_pkg::*;
(
  input  logic [3:0]  in_i,
  input  logic [3:0]  in_q,
  input  logic [1:0]  mode,
  output logic [7:0]  sample_bits,
  output slot_width_e slot_width
);

  always_comb begin
    sample_bits = 8'd0;
    slot_width  = SLOT_4B;
    case (mode)
      MODE_1B: begin
        sample_bits = {in_i[3], in_q[3], 6'd0};
        slot_width  = SLOT_2B;
      end
      MODE_4B: begin
        sample_bits = {in_i, in_q};
        slot_width  = SLOT_8B;
      end
      default: begin
        sample_bits = {in_i[3:2], in_q[3:2], 4'd0};
        slot_width  = SLOT_4B;
      end
    endcase
  end

endmodule

// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - decimates, requantizes and packs ADC samples into 16-bit words
module sample_packer #(
  parameter int WORDS_PER_PACKET = sample_packer_pkg::WORDS_PER_PACKET,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       in_i,
  input  logic [3:0]       in_q,
  input  logic             in_valid,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3:0]       decim,
  output logic [15:0]      out_data,
  output logic             out_en,
  output logic             busy,
  output logic [CNT_W-1:0] packet_count
);

  import sample_packer_pkg::*;

  localparam int WC_W = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_PACKET - 1);

  state_e            state;
  logic [1:0]        cfg_mode;
  logic [3:0]        cfg_decim;
  logic [3:0]        decim_cnt;
  logic [2:0]        slot_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [15:0]       sreg;
  logic [15:0]       sreg_next;
  logic [7:0]        sample_bits;
  slot_width_e       slot_width;
  logic [2:0]        last_slot;

  sample_requant u_requant (
    .in_i        (in_i),
    .in_q        (in_q),
    .mode        (cfg_mode),
    .sample_bits (sample_bits),
    .slot_width  (slot_width)
  );

  assign last_slot = 3'(samples_per_word(cfg_mode) - 4'd1);

  // Shifting left keeps the first sample of a word in the MSBs.
  always_comb begin
    sreg_next = sreg;
    case (slot_width)
      SLOT_2B: sreg_next = {sreg[13:0], sample_bits[7:6]};
      SLOT_4B: sreg_next = {sreg[11:0], sample_bits[7:4]};
      default: sreg_next = {sreg[7:0],  sample_bits};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cfg_mode     <= MODE_1B;
      cfg_decim    <= 4'd0;
      decim_cnt    <= 4'd0;
      slot_cnt     <= 3'd0;
      word_cnt     <= '0;
      sreg         <= 16'd0;
      out_data     <= 16'd0;
      out_en       <= 1'b0;
      busy         <= 1'b0;
      packet_count <= '0;
    end else begin
      out_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            cfg_mode  <= mode;
            cfg_decim <= decim;
            decim_cnt <= 4'd0;
            slot_cnt  <= 3'd0;
            word_cnt  <= '0;
            sreg      <= 16'd0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            // >= keeps the counter bounded if a smaller decim is loaded at a boundary.
            decim_cnt <= (decim_cnt >= cfg_decim) ? 4'd0 : decim_cnt + 4'd1;
            if (decim_cnt == 4'd0) begin
              if (slot_cnt == last_slot) begin
                out_data <= sreg_next;
                out_en   <= 1'b1;
                slot_cnt <= 3'd0;
                sreg     <= 16'd0;
                if (word_cnt == LAST_WORD) begin
                  packet_count <= packet_count + CNT_W'(1);
                  word_cnt     <= '0;
                  if (enable) begin
                    cfg_mode  <= mode;
                    cfg_decim <= decim;
                  end else begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                  end
                end else begin
                  word_cnt <= word_cnt + WC_W'(1);
                end
              end else begin
                slot_cnt <= slot_cnt + 3'd1;
                sreg     <= sreg_next;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
